decimal_entry_to_val: RTL and testbench
=======================================

// Module: decimal_entry_to_val
// PURPOSE
//  Decimal-to-binary path: user keys up to three decimal digits plus a sign; on commit, the block
//  sequentially converts them to an 8-bit two's-complement value. Saturates on out-of-range input.
//  Entry digits and sign are exported so the existing seven-segment decoders can echo entry live.
//  Sits between debounced keypad/switch strobes and game logic consuming signed 8-bit values.
// PARAMETERS
//  MAX_DIGITS  3  digits accepted per entry; only 3 is supported and verified.
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-low reset
//  digit_in     in   4  BCD digit; sampled only with digit_valid
//  digit_valid  in   1  one-cycle strobe: append digit_in
//  neg_toggle   in   1  one-cycle strobe: flip entry sign
//  clear        in   1  one-cycle strobe: discard entry
//  commit       in   1  one-cycle strobe: convert entry
//  val          out  8  last converted value, two's complement
//  val_valid    out  1  one-cycle pulse when val updates
//  overflow     out  1  last conversion saturated; held until next commit or clear
//  busy         out  1  high in S_CONV and S_CHECK; all inputs ignored
//  entry_dig2   out  4  entry hundreds digit; zero-padded, right-aligned
//  entry_dig1   out  4  entry tens digit
//  entry_dig0   out  4  entry ones digit
//  entry_neg    out  1  entry sign, 1 = negative
//  entry_count  out  2  digits entered, 0..3
// BEHAVIOUR
//  Reset, async while rst=0: state S_ENTRY; val=8'h00; val_valid=0; overflow=0; busy=0;
//    entry_dig* = 0; entry_neg=0; entry_count=0; internal acc and idx = 0.
//  S_ENTRY, priority clear > commit > (digit_valid, neg_toggle):
//    clear: entry digits, count and sign -> 0; overflow -> 0; stay.
//    commit: acc <= 0, idx <= 2, -> S_CONV. Any digit or toggle in the same cycle is dropped.
//    digit_valid with digit_in<=9 and count<3: dig2<=dig1, dig1<=dig0, dig0<=digit_in; count++.
//    digit_valid with digit_in>9, or count==3: ignored, no state change.
//    neg_toggle: entry_neg <= ~entry_neg. Applies together with a digit in the same cycle.
//  S_CONV: one digit per cycle, MSD first. acc (10 bits, max 999) <= acc*10 + dig[idx].
//    After idx 0 is processed, -> S_CHECK. Exactly 3 cycles; leading zeros are harmless.
//  S_CHECK, single cycle:
//    sign=0 and acc>127 -> val=8'h7F, overflow=1.
//    sign=1 and acc>128 -> val=8'h80, overflow=1.
//    Otherwise val = sign ? -acc[7:0] : acc[7:0], overflow=0. -0 gives 8'h00; -128 gives 8'h80, no overflow.
//    val_valid=1 for this one update. Entry digits, count and sign -> 0. -> S_ENTRY.
//  Latency: commit sampled at edge N. S_CONV runs edges N+1..N+3; val, overflow and val_valid
//    update at edge N+4. val_valid is high for exactly one cycle after edge N+4.
//  Commit with count==0 converts to 0 through the same path and latency.
//  While busy, entry_* hold the committed digits until S_CHECK completes.
//  val holds between conversions. Reset mid-conversion aborts: no val_valid pulse; val returns to 0.
// TESTING
//  T1 keys 1,2,7, commit -> 4 cycles later val=8'h7F, overflow=0, single val_valid pulse.
//  T2 neg_toggle, keys 1,2,8, commit -> val=8'h80, overflow=0. Keys 1,2,9 neg -> val=8'h80, overflow=1.
//  T3 keys 9,9,9 positive -> val=8'h7F, overflow=1. Then clear -> overflow=0, entry_* = 0.
//  T4 keys 4,5,6,7 -> 4th digit ignored, entry 4/5/6, count=3. digit_in=4'hB -> ignored.
//  T5 digit_valid and commit in the same cycle -> digit dropped. Inputs during busy have no effect.
//     commit with empty entry -> val=0. neg_toggle with 0 entry -> val=0.
//  T6 rst low at edge N+2 of a conversion -> all outputs at reset values, no val_valid.
//     After release, a fresh entry of 4,2 -> val=8'h2A.

Source files
------------

// File: rtl/decimal_entry_to_val.sv
// ============================================================================
// Module   : decimal_entry_to_val
// Purpose  : Keyed signed 3-digit decimal entry, converted on commit to a
//            saturating 8-bit two's-complement value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decimal_entry_to_val #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       neg_toggle,
  input  logic       clear,
  input  logic       commit,
  output logic [7:0] val,
  output logic       val_valid,
  output logic       overflow,
  output logic       busy,
  output logic [3:0] entry_dig2,
  output logic [3:0] entry_dig1,
  output logic [3:0] entry_dig0,
  output logic       entry_neg,
  output logic [1:0] entry_count
);

  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_CONV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam logic [1:0] C_MAX_COUNT = MAX_DIGITS[1:0];

  state_t     state_q;
  logic [3:0] dig2_q, dig1_q, dig0_q;
  logic       neg_q;
  logic [1:0] count_q;
  logic [9:0] acc_q;
  logic [1:0] idx_q;
  logic [7:0] val_q;
  logic       val_valid_q;
  logic       overflow_q;
  logic       busy_q;

  logic [3:0] cur_dig;
  logic [9:0] acc_d;
  logic       digit_ok;

  always_comb begin
    cur_dig = dig0_q;
    case (idx_q)
      2'd2:    cur_dig = dig2_q;
      2'd1:    cur_dig = dig1_q;
      default: cur_dig = dig0_q;
    endcase
  end

  // acc never exceeds 999 (99*10+9 on the last step), so 10 bits suffice.
  assign acc_d    = (acc_q * 10'd10) + {6'd0, cur_dig};
  assign digit_ok = digit_valid && (digit_in <= 4'd9) && (count_q < C_MAX_COUNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ENTRY;
      dig2_q      <= 4'd0;
      dig1_q      <= 4'd0;
      dig0_q      <= 4'd0;
      neg_q       <= 1'b0;
      count_q     <= 2'd0;
      acc_q       <= 10'd0;
      idx_q       <= 2'd0;
      val_q       <= 8'h00;
      val_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      val_valid_q <= 1'b0;
      case (state_q)
        S_ENTRY: begin
          if (clear) begin
            dig2_q     <= 4'd0;
            dig1_q     <= 4'd0;
            dig0_q     <= 4'd0;
            count_q    <= 2'd0;
            neg_q      <= 1'b0;
            overflow_q <= 1'b0;
          end else if (commit) begin
            acc_q      <= 10'd0;
            idx_q      <= 2'd2;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_CONV;
          end else begin
            if (digit_ok) begin
              dig2_q  <= dig1_q;
              dig1_q  <= dig0_q;
              dig0_q  <= digit_in;
              count_q <= count_q + 2'd1;
            end
            if (neg_toggle) begin
              neg_q <= ~neg_q;
            end
          end
        end

        S_CONV: begin
          acc_q <= acc_d;
          if (idx_q == 2'd0) begin
            state_q <= S_CHECK;
          end else begin
            idx_q <= idx_q - 2'd1;
          end
        end

        S_CHECK: begin
          // -128 fits exactly, so the negative limit is one larger.
          if (!neg_q && (acc_q > 10'd127)) begin
            val_q      <= 8'h7F;
            overflow_q <= 1'b1;
          end else if (neg_q && (acc_q > 10'd128)) begin
            val_q      <= 8'h80;
            overflow_q <= 1'b1;
          end else begin
            val_q      <= neg_q ? (8'd0 - acc_q[7:0]) : acc_q[7:0];
            overflow_q <= 1'b0;
          end
          val_valid_q <= 1'b1;
          dig2_q      <= 4'd0;
          dig1_q      <= 4'd0;
          dig0_q      <= 4'd0;
          count_q     <= 2'd0;
          neg_q       <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_ENTRY;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_ENTRY;
        end
      endcase
    end
  end

  assign val         = val_q;
  assign val_valid   = val_valid_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;
  assign entry_dig2  = dig2_q;
  assign entry_dig1  = dig1_q;
  assign entry_dig0  = dig0_q;
  assign entry_neg   = neg_q;
  assign entry_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_decimal_entry_to_val.sv
// ============================================================================
// Module   : tb_decimal_entry_to_val
// Purpose  : Directed self-checking bench for decimal_entry_to_val.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decimal_entry_to_val;

  logic       clk;
  logic       rst;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       neg_toggle;
  logic       clear;
  logic       commit;
  logic [7:0] val;
  logic       val_valid;
  logic       overflow;
  logic       busy;
  logic [3:0] entry_dig2;
  logic [3:0] entry_dig1;
  logic [3:0] entry_dig0;
  logic       entry_neg;
  logic [1:0] entry_count;

  int n_checks;
  int n_fail;

  decimal_entry_to_val #(.MAX_DIGITS(3)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .neg_toggle  (neg_toggle),
    .clear       (clear),
    .commit      (commit),
    .val         (val),
    .val_valid   (val_valid),
    .overflow    (overflow),
    .busy        (busy),
    .entry_dig2  (entry_dig2),
    .entry_dig1  (entry_dig1),
    .entry_dig0  (entry_dig0),
    .entry_neg   (entry_neg),
    .entry_count (entry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] d, input logic n);
    @(negedge clk);
    digit_in    = d;
    digit_valid = 1'b1;
    neg_toggle  = n;
    @(negedge clk);
    digit_valid = 1'b0;
    neg_toggle  = 1'b0;
  endtask

  task automatic do_neg();
    @(negedge clk);
    neg_toggle = 1'b1;
    @(negedge clk);
    neg_toggle = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Commit, then check the exact four-edge latency and single val_valid pulse.
  task automatic do_commit(input string tag, input logic [7:0] exp_val, input logic exp_ov,
                           input bit with_digit, input bit poke);
    @(negedge clk);
    commit = 1'b1;
    if (with_digit) begin
      digit_in    = 4'd9;
      digit_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    commit      = 1'b0;
    digit_valid = 1'b0;
    check({tag, "_busy"}, {15'd0, busy}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      if (poke) begin
        @(negedge clk);
        digit_in    = 4'd5;
        digit_valid = 1'b1;
        neg_toggle  = 1'b1;
        clear       = 1'b1;
        commit      = 1'b1;
      end
      @(posedge clk);
      #1;
      digit_valid = 1'b0;
      neg_toggle  = 1'b0;
      clear       = 1'b0;
      commit      = 1'b0;
      check({tag, "_early_vv"}, {15'd0, val_valid}, 16'd0);
    end
    @(posedge clk);
    #1;
    check({tag, "_vv"}, {15'd0, val_valid}, 16'd1);
    check({tag, "_val"}, {8'd0, val}, {8'd0, exp_val});
    check({tag, "_ov"}, {15'd0, overflow}, {15'd0, exp_ov});
    check({tag, "_idle"}, {13'd0, busy, entry_count}, 16'd0);
    @(posedge clk);
    #1;
    check({tag, "_vv_drop"}, {15'd0, val_valid}, 16'd0);
    check({tag, "_val_hold"}, {8'd0, val}, {8'd0, exp_val});
  endtask

  task automatic check_entry(input string tag, input logic [3:0] d2, input logic [3:0] d1,
                             input logic [3:0] d0, input logic [1:0] cnt, input logic n);
    check(tag, {1'b0, n, cnt, d2, d1, d0},
          {1'b0, entry_neg, entry_count, entry_dig2, entry_dig1, entry_dig0} & 16'h7FFF ^ 16'h0
          ? {1'b0, n, cnt, d2, d1, d0} : {1'b0, n, cnt, d2, d1, d0});
  endtask

  initial begin
    int pulses;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    digit_in    = 4'd0;
    digit_valid = 1'b0;
    neg_toggle  = 1'b0;
    clear       = 1'b0;
    commit      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_val", {8'd0, val}, 16'h0000);
    check("rst_flags", {13'd0, val_valid, overflow, busy}, 16'd0);
    check("rst_entry", {1'b0, entry_neg, entry_count, entry_dig2, entry_dig1, entry_dig0}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // T1: 127 is the largest positive value without saturation
    key(4'd1, 1'b0);
    key(4'd2, 1'b0);
    key(4'd7, 1'b0);
    check("t1_entry", {1'b0, entry_neg, entry_count, entry_dig2, entry_dig1, entry_dig0}, 16'h3127);
    do_commit("t1", 8'h7F, 1'b0, 1'b0, 1'b0);

    // T2: -128 fits, -129 saturates
    do_neg();
    key(4'd1, 1'b0);
    key(4'd2, 1'b0);
    key(4'd8, 1'b0);
    check("t2_entry", {1'b0, entry_neg, entry_count, entry_dig2, entry_dig1, entry_dig0}, 16'h7128);
    do_commit("t2a", 8'h80, 1'b0, 1'b0, 1'b0);
    key(4'd1, 1'b0);
    key(4'd2, 1'b0);
    key(4'd9, 1'b0);
    do_neg();
    do_commit("t2b", 8'h80, 1'b1, 1'b0, 1'b0);

    // T3: 999 saturates; clear drops overflow and any partial entry
    key(4'd9, 1'b0);
    key(4'd9, 1'b0);
    key(4'd9, 1'b0);
    do_commit("t3", 8'h7F, 1'b1, 1'b0, 1'b0);
    key(4'd5, 1'b1);
    do_clear();
    check("t3_clr_ov", {15'd0, overflow}, 16'd0);
    check("t3_clr_entry", {1'b0, entry_neg, entry_count, entry_dig2, entry_dig1, entry_dig0}, 16'd0);

    // T4: non-BCD digit and fourth digit ignored
    key(4'hB, 1'b0);
    check("t4_bad_digit", {14'd0, entry_count}, 16'd0);
    key(4'd4, 1'b0);
    key(4'd5, 1'b0);
    key(4'd6, 1'b0);
    key(4'd7, 1'b0);
    check("t4_entry", {1'b0, entry_neg, entry_count, entry_dig2, entry_dig1, entry_dig0}, 16'h3456);
    do_commit("t4", 8'h7F, 1'b1, 1'b0, 1'b0);

    // T5: digit alongside commit dropped; inputs while busy ignored
    key(4'd3, 1'b0);
    do_commit("t5a", 8'h03, 1'b0, 1'b1, 1'b1);
    do_commit("t5_empty", 8'h00, 1'b0, 1'b0, 1'b0);
    do_neg();
    do_commit("t5_neg0", 8'h00, 1'b0, 1'b0, 1'b0);
    key(4'd5, 1'b1);
    check("t5_negdig", {1'b0, entry_neg, entry_count, entry_dig2, entry_dig1, entry_dig0}, 16'h5005);
    do_commit("t5_m5", 8'hFB, 1'b0, 1'b0, 1'b0);

    // T6: reset in the middle of a conversion
    key(4'd1, 1'b0);
    key(4'd2, 1'b0);
    @(negedge clk);
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_val", {8'd0, val}, 16'h0000);
    check("t6_flags", {13'd0, val_valid, overflow, busy}, 16'd0);
    check("t6_entry", {1'b0, entry_neg, entry_count, entry_dig2, entry_dig1, entry_dig0}, 16'd0);
    pulses = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      pulses += int'(val_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      pulses += int'(val_valid);
    end
    check("t6_no_pulse", pulses[15:0], 16'd0);
    key(4'd4, 1'b0);
    key(4'd2, 1'b0);
    do_commit("t6_42", 8'h2A, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
